// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, line levels and parity helper
// Contents: state_e (IDLE/START/DATA/STOP/PARITY), DATA_BITS, START_LVL,
// STOP_LVL, IDLE_LVL, even_par().
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_e;
  localparam int DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
  localparam logic IDLE_LVL = 1'b1;
  function automatic logic even_par(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: host-side bus of the UART transmitter
// master (host): drives data_in, wr_en, clr_ovrflw; sees Tx, buf_full, tx_busy, overflow.
// slave (uart_tx_frame): the mirror image.
interface uart_tx_frame_if;
  logic [uart_pkg::DATA_BITS-1:0] data_in;
  logic wr_en;
  logic clr_ovrflw;
  logic Tx;
  logic buf_full;
  logic tx_busy;
  logic overflow;
  modport master (output data_in, wr_en, clr_ovrflw, input Tx, buf_full, tx_busy, overflow);
  modport slave (input data_in, wr_en, clr_ovrflw, output Tx, buf_full, tx_busy, overflow);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter, 0..CLKS_PER_BIT-1, tick on terminal count
// Ports: CLOCK, reset (sync, active-low), clr (hold counter at 0), tick (one-cycle strobe).
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W = 16
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign tick = !clr && cnt_q == CNT_W'(CLKS_PER_BIT - 1);
  assign cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge CLOCK) cnt_q <= !reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, one-byte holding buffer feeding an 8N1 LSB-first shifter
// Ports: CLOCK, reset (sync, active-low), bus (uart_tx_frame_if.slave:
// data_in/wr_en/clr_ovrflw in; Tx/buf_full/tx_busy/overflow out, all registered).
// Build option: define UART_TX_PARITY_EN to append an even-parity bit (11-bit frame).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W = 16
) (
  input logic CLOCK,
  input logic reset,
  uart_tx_frame_if.slave bus
);
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  state_e state_q, state_d;
  logic [DATA_BITS-1:0] buf_q, shift_q;
  logic [2:0] idx_q;
  logic tx_q, tx_d, full_q, busy_q, ovf_q, par_q;
  logic tick, last, load, accept;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_tick (
    .CLOCK(CLOCK),
    .reset(reset),
    .clr(state_q == IDLE),
    .tick(tick)
  );
  assign last = idx_q == 3'(DATA_BITS - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = full_q ? START : IDLE;
      START:   state_d = tick ? DATA : START;
      DATA:    state_d = (tick && last) ? (PAR_EN ? PARITY : STOP) : DATA;
      PARITY:  state_d = tick ? STOP : PARITY;
      STOP:    state_d = tick ? (full_q ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
  end
  // Entering START from IDLE or STOP is the only moment the buffer drains,
  // so a write on that same edge still finds room.
  assign load = state_d == START && state_q != START;
  assign accept = bus.wr_en && (!full_q || load);
  always_comb begin
    tx_d = tx_q;
    if (load) tx_d = START_LVL;
    else if (tick)
      tx_d = state_q == START ? shift_q[0] :
             state_q == DATA ? (last ? (PAR_EN ? par_q : STOP_LVL) : shift_q[1]) :
             STOP_LVL;
  end
  always_ff @(posedge CLOCK) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q <= '0;
      shift_q <= '0;
      idx_q <= '0;
      tx_q <= IDLE_LVL;
      full_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
      par_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      busy_q <= state_d != IDLE;
      full_q <= accept || (full_q && !load);
      ovf_q <= !bus.clr_ovrflw && (ovf_q || (bus.wr_en && !accept));
      if (accept) buf_q <= bus.data_in;
      if (load) begin
        shift_q <= buf_q;
        par_q <= even_par(buf_q);
      end else if (state_q == DATA && tick) shift_q <= shift_q >> 1;
      if (state_q == START) idx_q <= '0;
      else if (state_q == DATA && tick) idx_q <= idx_q + 1'b1;
    end
  end
  assign bus.Tx = tx_q;
  assign bus.buf_full = full_q;
  assign bus.tx_busy = busy_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for uart_tx_frame (CLKS_PER_BIT=4)
module tb_uart_tx_frame;
  import uart_pkg::*;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  typedef struct {
    logic [10:0] bits;
    int st;
  } frame_t;
  logic CLOCK = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  frame_t obs_q[$];
  logic [7:0] exp_q[$];
  uart_tx_frame_if bus();
  uart_tx_frame #(.CLKS_PER_BIT(C), .CNT_W(8)) dut (
    .CLOCK(CLOCK),
    .reset(reset),
    .bus(bus)
  );
  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;
  function automatic logic [10:0] frame_of(input logic [7:0] e);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^e, e, 1'b0};
`else
    return {1'b0, 1'b1, e, 1'b0};
`endif
  endfunction
  initial begin : mon
    frame_t f;
    bit ab;
    forever begin
      @(negedge CLOCK);
      if (reset === 1'b1 && bus.Tx === 1'b0) begin
        f.bits = '0;
        f.st = cyc;
        ab = 1'b0;
        for (int c = 1; c <= C * NB - C / 2 && !ab; c++) begin
          @(negedge CLOCK);
          if (reset !== 1'b1) ab = 1'b1;
          else if (c % C == C / 2) f.bits[c / C] = bus.Tx;
        end
        if (!ab) obs_q.push_back(f);
      end
    end
  end
  initial begin : watchdog
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask
  task automatic write(input logic [7:0] b);
    bus.data_in = b;
    bus.wr_en = 1'b1;
    step();
    bus.wr_en = 1'b0;
    bus.data_in = 8'($urandom);
  endtask
  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < 8 * C * NB && (bus.tx_busy || bus.buf_full); i++) begin
      step();
      if (bus.tx_busy) n++;
    end
  endtask
  task automatic get_frame(output frame_t f, output bit ok);
    for (int i = 0; i < 4 * C * NB && obs_q.size() == 0; i++) step();
    ok = obs_q.size() > 0;
    f.bits = '0;
    f.st = 0;
    if (ok) f = obs_q.pop_front();
  endtask
  task automatic test_reset();
    bus.wr_en = 1'b0;
    bus.clr_ovrflw = 1'b0;
    bus.data_in = '0;
    reset = 1'b0;
    repeat (3) step();
    checks++; if (bus.Tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", bus.Tx); end
    checks++; if (bus.buf_full !== 1'b0) begin failures++; $display("FAIL reset_buf_full got=%b exp=0", bus.buf_full); end
    checks++; if (bus.tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.tx_busy); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    reset = 1'b1;
    step();
  endtask
  task automatic test_single();
    frame_t f;
    bit ok;
    int n;
    logic [7:0] e;
    write(8'hA5);
    exp_q.push_back(8'hA5);
    checks++; if (bus.buf_full !== 1'b1 || bus.Tx !== 1'b1) begin failures++; $display("FAIL single_accept got=full%b tx%b exp=full1 tx1", bus.buf_full, bus.Tx); end
    step();
    checks++; if (bus.Tx !== 1'b0 || bus.buf_full !== 1'b0 || bus.tx_busy !== 1'b1) begin failures++; $display("FAIL single_start got=tx%b full%b busy%b exp=tx0 full0 busy1", bus.Tx, bus.buf_full, bus.tx_busy); end
    drain(n);
    checks++; if (n + 1 != C * NB) begin failures++; $display("FAIL single_busy_len got=%0d exp=%0d", n + 1, C * NB); end
    while (exp_q.size() > 0) begin
      get_frame(f, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || f.bits !== frame_of(e)) begin failures++; $display("FAIL single_frame got=%h ok=%0d exp=%h", f.bits, ok, frame_of(e)); end
    end
  endtask
  task automatic test_back_to_back();
    frame_t f0, f1;
    bit ok0, ok1;
    int n, nb;
    nb = 0;
    write(8'h00);
    exp_q.push_back(8'h00);
    repeat (10) begin
      step();
      if (bus.tx_busy) nb++;
    end
    write(8'hFF);
    exp_q.push_back(8'hFF);
    if (bus.tx_busy) nb++;
    drain(n);
    nb += n;
    checks++; if (nb != 2 * C * NB) begin failures++; $display("FAIL b2b_busy_len got=%0d exp=%0d", nb, 2 * C * NB); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", bus.overflow); end
    get_frame(f0, ok0);
    get_frame(f1, ok1);
    checks++; if (!ok0 || f0.bits !== frame_of(exp_q[0])) begin failures++; $display("FAIL b2b_frame0 got=%h exp=%h", f0.bits, frame_of(exp_q[0])); end
    checks++; if (!ok1 || f1.bits !== frame_of(exp_q[1])) begin failures++; $display("FAIL b2b_frame1 got=%h exp=%h", f1.bits, frame_of(exp_q[1])); end
    checks++; if (f1.st - f0.st != C * NB) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", f1.st - f0.st, C * NB); end
    exp_q.delete();
  endtask
  task automatic test_overflow();
    frame_t f;
    bit ok;
    int n;
    logic [7:0] e;
    write(8'h11);
    exp_q.push_back(8'h11);
    write(8'h22);
    exp_q.push_back(8'h22);
    write(8'h33);
    checks++; if (bus.overflow !== 1'b1 || bus.buf_full !== 1'b1) begin failures++; $display("FAIL ovf_set got=ovf%b full%b exp=ovf1 full1", bus.overflow, bus.buf_full); end
    drain(n);
    checks++; if (bus.overflow !== 1'b1 || bus.tx_busy !== 1'b0) begin failures++; $display("FAIL ovf_sticky got=ovf%b busy%b exp=ovf1 busy0", bus.overflow, bus.tx_busy); end
    while (exp_q.size() > 0) begin
      get_frame(f, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || f.bits !== frame_of(e)) begin failures++; $display("FAIL ovf_frame got=%h ok=%0d exp=%h", f.bits, ok, frame_of(e)); end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL ovf_extra_frames got=%0d exp=0", obs_q.size()); end
    bus.clr_ovrflw = 1'b1;
    step();
    bus.clr_ovrflw = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
  endtask
  task automatic test_simultaneous();
    frame_t f;
    bit ok;
    int n;
    logic [7:0] e;
    write(8'h44);
    exp_q.push_back(8'h44);
    write(8'h55);
    exp_q.push_back(8'h55);
    checks++; if (bus.overflow !== 1'b0 || bus.buf_full !== 1'b1) begin failures++; $display("FAIL sim_xfer_write got=ovf%b full%b exp=ovf0 full1", bus.overflow, bus.buf_full); end
    repeat (3) step();
    write(8'h77);
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL sim_drop_sets got=%b exp=1", bus.overflow); end
    bus.clr_ovrflw = 1'b1;
    write(8'h66);
    bus.clr_ovrflw = 1'b0;
    checks++; if (bus.overflow !== 1'b0 || bus.buf_full !== 1'b1) begin failures++; $display("FAIL sim_clr_drop got=ovf%b full%b exp=ovf0 full1", bus.overflow, bus.buf_full); end
    drain(n);
    while (exp_q.size() > 0) begin
      get_frame(f, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || f.bits !== frame_of(e)) begin failures++; $display("FAIL sim_frame got=%h ok=%0d exp=%h", f.bits, ok, frame_of(e)); end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL sim_extra_frames got=%0d exp=0", obs_q.size()); end
  endtask
  task automatic test_reset_mid_frame();
    frame_t f;
    bit ok;
    int n;
    logic [7:0] e;
    write(8'h96);
    write(8'hC3);
    repeat (17) step();
    checks++; if (bus.tx_busy !== 1'b1 || bus.buf_full !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=busy%b full%b exp=busy1 full1", bus.tx_busy, bus.buf_full); end
    reset = 1'b0;
    step();
    checks++; if (bus.Tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.buf_full !== 1'b0) begin failures++; $display("FAIL rst_mid_abort got=tx%b busy%b full%b exp=tx1 busy0 full0", bus.Tx, bus.tx_busy, bus.buf_full); end
    reset = 1'b1;
    repeat (2) step();
    write(8'h3C);
    exp_q.push_back(8'h3C);
    drain(n);
    while (exp_q.size() > 0) begin
      get_frame(f, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || f.bits !== frame_of(e)) begin failures++; $display("FAIL rst_mid_frame got=%h ok=%0d exp=%h", f.bits, ok, frame_of(e)); end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rst_mid_extra got=%0d exp=0", obs_q.size()); end
  endtask
`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    frame_t f;
    bit ok;
    int n;
    write(8'h07);
    drain(n);
    get_frame(f, ok);
    checks++; if (!ok || f.bits[9] !== 1'b1 || f.bits[10] !== 1'b1 || f.bits[8:1] !== 8'h07) begin failures++; $display("FAIL parity_07 got=%h exp=%h", f.bits, 11'h60E); end
    checks++; if (n + 1 != 11 * C) begin failures++; $display("FAIL parity_len got=%0d exp=%0d", n + 1, 11 * C); end
    write(8'h03);
    drain(n);
    get_frame(f, ok);
    checks++; if (!ok || f.bits[9] !== 1'b0 || f.bits[10] !== 1'b1 || f.bits[8:1] !== 8'h03) begin failures++; $display("FAIL parity_03 got=%h exp=%h", f.bits, 11'h406); end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Transmit half of the UART: accepts bytes from the CPU/host side into a one-byte holding buffer and serialises them on Tx.
- Frame format: 8N1, LSB first (1 start bit, 8 data bits, 1 stop bit).
- The holding buffer plus the active shift register give two-byte elasticity.
- Flag semantics mirror the receive side: buffer full/empty, overflow with explicit clear.

Parameters:
- CLKS_PER_BIT, 16: CLOCK cycles per serial bit. Legal range is ≥2. Sets the baud rate (e.g. 50 MHz / 115200 → 434).
- CNT_W, 16: width of the baud counter. Must satisfy 2**CNT_W > CLKS_PER_BIT.

Ports:
- CLOCK  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- data_in  in  8  byte to transmit.
- wr_en  in  1  write strobe; one-cycle pulse; data_in sampled on the same edge.
- clr_ovrflw  in  1  clears overflow.
- Tx  out  1  serial line, registered, idle high.
- buf_full  out  1  holding buffer occupied.
- tx_busy  out  1  frame in progress (FSM not IDLE).
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (reset=0 at a posedge):
  - Tx=1, buf_full=0, tx_busy=0, overflow=0.
  - FSM goes to IDLE; baud counter, bit index, buffer and shift register are cleared.
  - Reset mid-frame aborts the frame immediately; Tx returns high on that edge.
- Write acceptance at edge k with wr_en=1:
  - If buffer empty, or being emptied on this same edge: buffer<=data_in, buf_full=1.
  - Otherwise the byte is dropped, the buffer is unchanged and overflow<=1.
- Overflow register:
  - clr_ovrflw has priority over set.
  - Simultaneous clr_ovrflw and a dropped write leaves overflow=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: Tx=1. If buf_full: shift<=buffer, buf_full<=0, state<=START, Tx<=0, baud counter<=0.
  - START: holds Tx=0 for CLKS_PER_BIT cycles, then goes to DATA with Tx<=shift[0] and bit index<=0.
  - DATA: each bit is held for CLKS_PER_BIT cycles, then the register shifts right and Tx<=next LSB. After bit 7's period, state<=STOP and Tx<=1.
  - STOP: Tx=1 for CLKS_PER_BIT cycles, then state<=IDLE.
- Back-to-back frames:
  - Leaving STOP with buf_full=1 goes directly to START on that edge, so there are no idle cycles between frames.
- Latency:
  - wr_en at edge k into an idle block → buf_full high after k, Tx low after edge k+1.
  - Frame length is exactly 10×CLKS_PER_BIT cycles (11× with parity enabled).
- tx_busy is registered and equals (state != IDLE).
- Baud counter: counts 0..CLKS_PER_BIT-1; terminal count is the bit-advance strobe. It wraps to 0 and never free-runs in IDLE.
- Changes to data_in after acceptance have no effect on the frame.

Optional Feature:
- UART_TX_PARITY_EN
  - Defined: adds state PARITY between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 11-bit frame.
  - Undefined: no PARITY state; 10-bit 8N1 frame.

Decomposition:
- Package uart_pkg holds:
  - the state enumeration (IDLE/START/DATA/STOP/PARITY);
  - DATA_BITS=8, START_LVL=1'b0, STOP_LVL=1'b1, IDLE_LVL=1'b1.
- Sub-module uart_baud_tick: parameterised counter with a start/clear input and a one-cycle tick output. It is shared with the receive side's sampling logic.

Test Plan:
- Single byte: CLKS_PER_BIT=4, reset, write 0xA5 → Tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. Tx low on the 2nd edge after wr_en; tx_busy high 40 cycles; buf_full high 1 cycle.
- Back-to-back: write 0x00, then 0xFF during the first frame → the second start bit immediately follows the first stop bit. Total 80 busy cycles with no idle gap; overflow stays 0.
- Overflow: write 0x11 and 0x22, then 0x33 while buf_full=1 → overflow=1, 0x33 is never transmitted, 0x11 and 0x22 are sent intact. Pulse clr_ovrflw → overflow=0.
- Simultaneous events:
  - wr_en on the same edge the buffer transfers to the shift register → accepted, no overflow.
  - clr_ovrflw together with a dropped write → overflow=0.
- Reset mid-frame: assert reset=0 during DATA bit 3 → next edge has Tx=1, tx_busy=0, buf_full=0. A new write of 0x3C then transmits a correct full frame.
- With UART_TX_PARITY_EN: write 0x07 → parity bit 1, 11-bit frame; write 0x03 → parity bit 0.
